// File: rtl/fft_twiddle_sequencer_if.sv
// Control, twiddle-ROM and twiddle-stream bundle of fft_twiddle_sequencer.
// The master side belongs to the sequencer; the slave side is the ROM/consumer.
interface fft_twiddle_sequencer_if #(
    parameter int LOG2N = 5,
    parameter int DW    = 16,
    parameter int AW    = 5
);
    logic                 start;
    logic                 all_stages;
    logic [2:0]           stage_sel;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_re_data;
    logic [DW-1:0]        rom_im_data;
    logic                 tw_valid;
    logic                 tw_ready;
    logic [DW-1:0]        tw_re;
    logic [DW-1:0]        tw_im;
    logic [2:0]           tw_stage;
    logic [LOG2N-2:0]     tw_bfly;

    modport master (
        input  start, all_stages, stage_sel, rom_re_data, rom_im_data, tw_ready,
        output busy, done, err, rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_bfly
    );

    modport slave (
        output start, all_stages, stage_sel, rom_re_data, rom_im_data, tw_ready,
        input  busy, done, err, rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_bfly
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Walks the radix-2 FFT butterflies, reads twiddles from a registered ROM pair and
// streams them through a 2-entry FIFO under valid/ready backpressure.
module fft_twiddle_sequencer #(
    parameter int NPTS  = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 16,
    parameter int AW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_twiddle_sequencer_if.master bus
);
    localparam int              BW     = LOG2N - 1;
    localparam logic [BW-1:0]   B_LAST = BW'(NPTS / 2 - 1);
    localparam logic [2:0]      S_LAST = 3'(LOG2N - 1);
    localparam logic [BW-1:0]   B_ONE  = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    stage;
        logic [BW-1:0] bfly;
    } entry_t;

    // Twiddle index for butterfly b of stage s: (b mod 2^s) << (LOG2N-1-s).
    function automatic logic [AW-1:0] tw_addr(input logic [BW-1:0] b, input logic [2:0] s);
        logic [BW:0]      span;
        logic [BW-1:0]    wrapped;
        logic [AW+BW-1:0] wide;
        span         = {{BW{1'b0}}, 1'b1} << s;
        wrapped      = b & BW'(span - {{BW{1'b0}}, 1'b1});
        wide         = '0;
        wide[BW-1:0] = wrapped;
        wide         = wide << (S_LAST - s);
        return wide[AW-1:0];
    endfunction

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          all_q;
    logic [2:0]    s_q;
    logic [BW-1:0] b_q;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    logic [2:0]    rd_stage_q;
    logic [BW-1:0] rd_bfly_q;

    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          vld_q;
    entry_t        head_q;
    entry_t        head_d;
    entry_t        tail_q;
    entry_t        tail_d;
    entry_t        in_s;

    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic          last_issue_s;
    logic          accept_s;
    logic          reject_s;
    logic [1:0]    occ_s;
    logic [BW-1:0] b_nxt_s;

    // Handshake, read-credit and start-qualification decode.
    always_comb begin
        pop_s   = vld_q & bus.tw_ready;
        push_s  = rd_q;
        b_nxt_s = b_q + B_ONE;
        // Occupancy counts this cycle's pop as already gone so a full-rate stream never bubbles.
        occ_s   = cnt_q + {1'b0, rd_q} - {1'b0, pop_s};
        if (state_q == RUN) begin
            issue_s = (occ_s < 2'd2);
        end else begin
            issue_s = 1'b0;
        end
        if (issue_s && (b_q == B_LAST)) begin
            last_issue_s = !all_q || (s_q == S_LAST);
        end else begin
            last_issue_s = 1'b0;
        end
        if ((state_q == IDLE) && bus.start && !done_q) begin
            if (bus.all_stages || (bus.stage_sel <= S_LAST)) begin
                accept_s = 1'b1;
                reject_s = 1'b0;
            end else begin
                accept_s = 1'b0;
                reject_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Sequencer FSM: butterfly/stage counters, ROM address, read tag pipeline and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            all_q      <= 1'b0;
            s_q        <= 3'd0;
            b_q        <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            rd_stage_q <= 3'd0;
            rd_bfly_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= reject_s;
            rd_q       <= issue_s;
            rd_stage_q <= s_q;
            rd_bfly_q  <= b_q;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        all_q   <= bus.all_stages;
                        s_q     <= bus.all_stages ? 3'd0 : bus.stage_sel;
                        b_q     <= '0;
                        addr_q  <= '0;
                    end
                end
                RUN: begin
                    if (issue_s) begin
                        if (b_q == B_LAST) begin
                            b_q    <= '0;
                            addr_q <= '0;
                            if (last_issue_s) begin
                                state_q <= DRAIN;
                            end else begin
                                s_q <= s_q + 3'd1;
                            end
                        end else begin
                            b_q    <= b_nxt_s;
                            addr_q <= tw_addr(b_nxt_s, s_q);
                        end
                    end
                end
                DRAIN: begin
                    // Nothing in flight and the last entry leaving now: finish next cycle.
                    if (occ_s == 2'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry FIFO kept as head/tail registers so the stream outputs come straight from flops.
    always_comb begin
        in_s   = {bus.rom_re_data, bus.rom_im_data, rd_stage_q, rd_bfly_q};
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = in_s;
                end else begin
                    tail_d = in_s;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = in_s;
                end else begin
                    head_d = tail_q;
                    tail_d = in_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            vld_q  <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            vld_q  <= (cnt_d != 2'd0);
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rom_addr = addr_q;
    assign bus.tw_valid = vld_q;
    assign bus.tw_re    = head_q.re;
    assign bus.tw_im    = head_q.im;
    assign bus.tw_stage = head_q.stage;
    assign bus.tw_bfly  = head_q.bfly;
endmodule

// File: doc/fft_twiddle_sequencer.md
FFT_TWIDDLE_SEQUENCER -- requirements
Module: fft_twiddle_sequencer

Interface
REQ-001 SHALL have parameter NPTS, default 32, meaning FFT length in points.
REQ-002 SHALL have parameter LOG2N, default 5, meaning number of radix-2 stages.
REQ-003 SHALL have parameter DW, default 16, meaning twiddle component width.
REQ-004 SHALL have parameter AW, default 5, meaning twiddle ROM address width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-008 SHALL have port all_stages  input  1  sampled at start; 1 = run stages 0..LOG2N-1 back to back.
REQ-009 SHALL have port stage_sel  input  3  sampled at start; single stage to run when all_stages=0.
REQ-010 SHALL have port busy  output  1  high from accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last twiddle handshake.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-013 SHALL have port rom_addr  output  AW  shared address to the real and imaginary twiddle ROMs.
REQ-014 SHALL have ports rom_re_data and rom_im_data  input  DW each  ROM outputs, registered, valid 1 cycle after rom_addr.
REQ-015 SHALL have ports tw_valid (output, 1), tw_ready (input, 1), tw_re and tw_im (output, DW each), tw_stage (output, 3) and tw_bfly (output, LOG2N-1): the twiddle stream.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 SHALL, in IDLE, accept start only when stage_sel<LOG2N or all_stages=1; go to RUN; assert busy the next cycle.
REQ-018 SHALL, on start with all_stages=0 and stage_sel>=LOG2N, stay IDLE and pulse err.
REQ-019 SHALL ignore start while busy=1, with no err.
REQ-020 SHALL, per stage s, issue butterflies b=0..NPTS/2-1 in order, driving rom_addr = (b mod 2^s) << (LOG2N-1-s), zero-extended to AW.
REQ-021 SHALL issue a ROM read in a cycle only when (FIFO occupancy + reads in flight) < 2, so that no data is lost under backpressure.
REQ-022 SHALL capture ROM data, with stage and butterfly tags delayed to match, into a 2-entry output FIFO one cycle after issue.
REQ-023 SHALL drive tw_valid = FIFO not empty and present the head entry; the entry pops when tw_valid and tw_ready are both high.
REQ-024 SHALL hold tw_re, tw_im, tw_stage and tw_bfly stable while tw_valid=1 and tw_ready=0.
REQ-025 SHALL, with tw_ready held at 1, sustain one twiddle per cycle; first tw_valid 2 cycles after the first issue.
REQ-026 SHALL, on the last issue of the last stage, go to DRAIN; wrap b to 0 and increment s when all_stages=1.
REQ-027 SHALL, in DRAIN, pulse done in the cycle after the final pop with the FIFO empty, then enter IDLE with busy=0.
REQ-028 SHALL handle a pop and a push in the same cycle as no change in occupancy.
REQ-029 SHALL NOT act on a start arriving in the same cycle as done; it is ignored.

Reset
REQ-030 SHALL, on rst, enter IDLE and flush the FIFO and in-flight tags; busy, done, err and tw_valid go to 0, and rom_addr, tw_re, tw_im, tw_stage and tw_bfly go to 0.
REQ-031 SHALL let rst abort a run mid-operation with no done pulse; rst has priority over start.

Verification
REQ-032 SHALL cover: start, stage_sel=1, tw_ready=1 -> 16 twiddles with rom_addr sequence 0,8,0,8,..., tw_bfly 0..15, done 1 cycle after the 16th handshake.
REQ-033 SHALL cover: start, stage_sel=4 -> rom_addr 0..15 in order; tw_re/tw_im equal the ROM contents at those addresses.
REQ-034 SHALL cover: start, all_stages=1 -> 80 handshakes, tw_stage stepping 0..4 every 16, a single done pulse.
REQ-035 SHALL cover: tw_ready toggling randomly, and tw_ready=0 held 10 cycles -> no loss, duplication or reordering; at most 2 reads outstanding; outputs stable while stalled.
REQ-036 SHALL cover: start, stage_sel=6, all_stages=0 -> err pulse, busy stays 0; start during busy -> ignored.
REQ-037 SHALL cover: rst asserted at butterfly 7 -> next cycle busy=0 and tw_valid=0, no done; a new start runs cleanly from b=0.
